// File: rtl/qos_emisor.sv
// qos_emisor: per-VC FIFOs feeding a round-robin emitter, with pause/resume per VC.
// Optional per-VC saturating emission counters are enabled by defining QOS_EMISOR_CONTADORES_EN.
module qos_emisor #(
   parameter int QUEUE_QUANTITY = 4,
   parameter int BUF_WIDTH      = 3,
   parameter int DEPTH          = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enb,
   input  logic                                wr_en,
   input  logic [$clog2(QUEUE_QUANTITY)-1:0]   wr_vc,
   input  logic [BUF_WIDTH:0]                  wr_data,
   input  logic [QUEUE_QUANTITY-1:0]           pausa,
   input  logic [QUEUE_QUANTITY-1:0]           continuar,
   output logic                                valid,
   output logic [$clog2(QUEUE_QUANTITY)-1:0]   vc_id,
   output logic [BUF_WIDTH:0]                  data_word,
   output logic [QUEUE_QUANTITY-1:0]           full,
   output logic                                wr_error,
   output logic [QUEUE_QUANTITY-1:0]           paused,
   output logic                                idle,
   output logic [QUEUE_QUANTITY*8-1:0]         sent_count
);
   localparam int VC_W  = $clog2(QUEUE_QUANTITY);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int DW    = BUF_WIDTH + 1;

   logic [DW-1:0]             mem [QUEUE_QUANTITY][DEPTH];
   logic [PTR_W-1:0]          rd_ptr [QUEUE_QUANTITY];
   logic [PTR_W-1:0]          wr_ptr [QUEUE_QUANTITY];
   logic [QUEUE_QUANTITY-1:0] eligible;
   logic [QUEUE_QUANTITY-1:0] empty;
   logic [VC_W-1:0]           rr_ptr_reg;
   logic [VC_W-1:0]           sel;
   logic                      pop;
   logic                      push;
   logic                      valid_reg;
   logic [VC_W-1:0]           vc_id_reg;
   logic [DW-1:0]             data_word_reg;
   logic                      wr_error_reg;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // First eligible VC at or above rr_ptr with wrap; scanning downward lets the lowest offset win.
   always_comb begin
      int idx;
      idx = 0;
      sel = '0;
      pop = 1'b0;
      for (int k = QUEUE_QUANTITY - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_reg) + k) % QUEUE_QUANTITY;
         if (eligible[idx]) begin
            pop = enb;
            sel = VC_W'(idx);
         end
      end
   end

   // A full queue still accepts a word when it is being popped on the same edge.
   assign push = enb && wr_en && (!full[wr_vc] || (pop && (sel == wr_vc)));

   generate
      for (genvar gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_vc
         logic [PTR_W-1:0] rd_reg;
         logic [PTR_W-1:0] wr_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic             pause_reg;
         logic             push_i;
         logic             pop_i;

         assign push_i = push && (wr_vc == VC_W'(gi));
         assign pop_i  = pop && (sel == VC_W'(gi));

         always_ff @(posedge clk) begin
            if (rst) begin
               rd_reg    <= '0;
               wr_reg    <= '0;
               cnt_reg   <= '0;
               pause_reg <= 1'b0;
            end else if (enb) begin
               if (push_i) wr_reg <= ptr_inc(wr_reg);
               if (pop_i)  rd_reg <= ptr_inc(rd_reg);
               case ({push_i, pop_i})
                  2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
                  2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
                  default: cnt_reg <= cnt_reg;
               endcase
               if (pausa[gi])          pause_reg <= 1'b1;
               else if (continuar[gi]) pause_reg <= 1'b0;
            end
         end

         assign rd_ptr[gi]   = rd_reg;
         assign wr_ptr[gi]   = wr_reg;
         assign paused[gi]   = pause_reg;
         assign empty[gi]    = (cnt_reg == '0);
         assign full[gi]     = (cnt_reg == CNT_W'(DEPTH));
         assign eligible[gi] = !empty[gi] && !pause_reg && !pausa[gi];
      end
   endgenerate

   // Storage has no reset so it maps onto block RAM; pointers alone define contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_vc][wr_ptr[wr_vc]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg    <= '0;
         valid_reg     <= 1'b0;
         vc_id_reg     <= '0;
         data_word_reg <= '0;
         wr_error_reg  <= 1'b0;
      end else begin
         wr_error_reg <= enb && wr_en && !push;
         valid_reg    <= pop;
         if (pop) begin
            vc_id_reg     <= sel;
            data_word_reg <= mem[sel][rd_ptr[sel]];
            rr_ptr_reg    <= (sel == VC_W'(QUEUE_QUANTITY - 1)) ? '0 : sel + 1'b1;
         end
      end
   end

   assign valid     = valid_reg;
   assign vc_id     = vc_id_reg;
   assign data_word = data_word_reg;
   assign wr_error  = wr_error_reg;
   assign idle      = (&empty) && !valid_reg;

`ifdef QOS_EMISOR_CONTADORES_EN
   generate
      for (genvar gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_cnt
         logic [7:0] sent_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               sent_reg <= '0;
            end else if (pop && (sel == VC_W'(gi)) && (sent_reg != 8'hFF)) begin
               sent_reg <= sent_reg + 8'd1;
            end
         end
         assign sent_count[gi*8 +: 8] = sent_reg;
      end
   endgenerate
`else
   assign sent_count = '0;
`endif

endmodule

// File: tb/tb_qos_emisor.sv
// Scoreboard bench for qos_emisor: expected emissions are queued as stimulus is driven
// and compared against valid words observed on the falling edge.
module tb_qos_emisor;
   logic        clk = 1'b0;
   logic        rst, enb, wr_en;
   logic [1:0]  wr_vc;
   logic [3:0]  wr_data;
   logic [3:0]  pausa, continuar;
   logic        valid;
   logic [1:0]  vc_id;
   logic [3:0]  data_word;
   logic [3:0]  full;
   logic        wr_error;
   logic [3:0]  paused;
   logic        idle;
   logic [31:0] sent_count;

   int         n_vec  = 0;
   int         n_err  = 0;
   int         n_emit = 0;
   int         n_mark = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_e;

   qos_emisor #(.QUEUE_QUANTITY(4), .BUF_WIDTH(3), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .enb(enb), .wr_en(wr_en), .wr_vc(wr_vc),
      .wr_data(wr_data), .pausa(pausa), .continuar(continuar),
      .valid(valid), .vc_id(vc_id), .data_word(data_word), .full(full),
      .wr_error(wr_error), .paused(paused), .idle(idle), .sent_count(sent_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input int vc, input int d);
      exp_q.push_back({4'(vc), 4'(d)});
   endtask

   task automatic write(input int vc, input int d);
      wr_en   = 1'b1;
      wr_vc   = 2'(vc);
      wr_data = 4'(d);
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      tick();
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         n_emit++;
         $display("emit vc=%0d data=%0d t=%0t", vc_id, data_word, $time);
         if (exp_q.size() == 0) begin
            check("spurious_valid", 32'(valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("vc_id", 32'(vc_id), 32'(mon_e[7:4]));
            check("data_word", 32'(data_word), 32'(mon_e[3:0]));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; enb = 1'b1; wr_en = 1'b0; wr_vc = '0; wr_data = '0;
      pausa = '0; continuar = '0;
      tick(); tick();
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_paused", 32'(paused), 32'd0);
      check("rst_wr_error", 32'(wr_error), 32'd0);
      check("rst_vc_id", 32'(vc_id), 32'd0);
      check("rst_data", 32'(data_word), 32'd0);
      check("rst_sent", sent_count, 32'd0);
      rst = 1'b0;

      // One word per VC, each emitted the cycle after it is written.
      expect_word(0, 8); write(0, 8);
      expect_word(1, 5); write(1, 5);
      expect_word(2, 2); write(2, 2);
      expect_word(3, 3); write(3, 3);
      drain("s1_drain", 20);
      check("s1_idle", 32'(idle), 32'd1);

      // Fill VC2 while everything is paused; the fifth write is dropped.
      pausa = 4'hF; tick(); pausa = '0;
      check("s2_paused", 32'(paused), 32'hF);
      for (int i = 1; i <= 5; i++) begin
         write(2, i);
         if (i == 4) begin
            check("s2_full4", 32'(full), 32'h4);
            check("s2_noerr4", 32'(wr_error), 32'd0);
         end
      end
      check("s2_err_pulse", 32'(wr_error), 32'd1);
      tick();
      check("s2_err_clear", 32'(wr_error), 32'd0);
      continuar = 4'hF; tick(); continuar = '0;
      check("s2_resumed", 32'(paused), 32'd0);
      check("s2_no_early", 32'(valid), 32'd0);
      for (int i = 1; i <= 4; i++) expect_word(2, i);
      expect_word(2, 6);
      write(2, 6);   // full queue popped on the same edge accepts the write
      check("s2_full_pp", 32'(wr_error), 32'd0);
      check("s2_full_keep", 32'(full), 32'h4);
      drain("s2_drain", 20);
      check("s2_idle", 32'(idle), 32'd1);

      // VC1 held by a pause, released by continuar.
      pausa = 4'h2; write(1, 10); pausa = '0;
      check("s3_paused", 32'(paused), 32'h2);
      write(1, 3);
      repeat (3) begin
         tick();
         check("s3_held", 32'(valid), 32'd0);
      end
      continuar = 4'h2; tick(); continuar = '0;
      check("s3_released", 32'(paused), 32'd0);
      check("s3_latency0", 32'(valid), 32'd0);
      expect_word(1, 10); expect_word(1, 3);
      tick();
      check("s3_first_valid", 32'(valid), 32'd1);
      check("s3_first_data", 32'(data_word), 32'd10);
      drain("s3_drain", 20);

      // pausa wins over continuar on the same edge.
      pausa = 4'h8; continuar = 4'h8; tick(); pausa = '0; continuar = '0;
      check("s4_tie", 32'(paused), 32'h8);
      continuar = 4'h8; tick(); continuar = '0;
      check("s4_clear", 32'(paused), 32'd0);

      // enb=0 freezes queues, pause state and ignores writes.
      expect_word(0, 5);
      wr_en = 1'b1; wr_vc = 2'd0; wr_data = 4'd5; tick();
      enb = 1'b0; wr_vc = 2'd1; wr_data = 4'd9; pausa = 4'hF;
      repeat (3) begin
         tick();
         check("frz_valid", 32'(valid), 32'd0);
         check("frz_err", 32'(wr_error), 32'd0);
      end
      check("frz_paused", 32'(paused), 32'd0);
      check("frz_busy", 32'(idle), 32'd0);
      wr_en = 1'b0; pausa = '0; enb = 1'b1;
      drain("frz_drain", 20);

      // Two words per VC, round-robin order, reset after the third emission.
      rst = 1'b1; tick(); rst = 1'b0;
      pausa = 4'hF; tick(); pausa = '0;
      for (int i = 0; i < 4; i++) write(i, 9 + i);
      for (int i = 0; i < 4; i++) write(i, 1 + i);
      continuar = 4'hF; tick(); continuar = '0;
      for (int i = 0; i < 4; i++) expect_word(i, 9 + i);
      for (int i = 0; i < 4; i++) expect_word(i, 1 + i);
      n_mark = n_emit;
      repeat (3) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      exp_q.delete();
      check("s5_emitted", 32'(n_emit - n_mark), 32'd3);
      check("s5_rst_valid", 32'(valid), 32'd0);
      check("s5_rst_idle", 32'(idle), 32'd1);
      check("s5_rst_full", 32'(full), 32'd0);
      expect_word(3, 7); write(3, 7);
      drain("s5_drain", 20);

      // 300 emissions on VC0 to exercise counter saturation.
      for (int i = 0; i < 300; i++) begin
         expect_word(0, i & 15);
         write(0, i & 15);
      end
      drain("s6_drain", 20);
`ifdef QOS_EMISOR_CONTADORES_EN
      check("s6_sent0", 32'(sent_count[7:0]), 32'd255);
      check("s6_sent3", 32'(sent_count[31:24]), 32'd1);
`else
      check("s6_sent0", 32'(sent_count[7:0]), 32'd0);
      check("s6_sent3", 32'(sent_count[31:24]), 32'd0);
`endif
      check("s6_sent12", 32'(sent_count[23:8]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/qos_emisor.md
QOS_EMISOR -- requirements
Module: qos_emisor

Interface
REQ-001 SHALL have parameter QUEUE_QUANTITY, default 4; number of virtual channels (VCs).
REQ-002 SHALL have parameter BUF_WIDTH, default 3; data words are BUF_WIDTH+1 bits wide.
REQ-003 SHALL have parameter DEPTH, default 4; words per VC queue, power of two.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit; synchronous active-high reset.
REQ-006 SHALL have port enb, input, 1 bit; global enable.
REQ-007 SHALL have port wr_en, input, 1 bit; host write strobe.
REQ-008 SHALL have port wr_vc, input, $clog2(QUEUE_QUANTITY) bits; target VC of the host write.
REQ-009 SHALL have port wr_data, input, BUF_WIDTH+1 bits; host write word.
REQ-010 SHALL have port pausa, input, QUEUE_QUANTITY bits; per-VC pause request from the QoS block.
REQ-011 SHALL have port continuar, input, QUEUE_QUANTITY bits; per-VC resume request from the QoS block.
REQ-012 SHALL have port valid, output, 1 bit; vc_id and data_word carry a word this cycle.
REQ-013 SHALL have port vc_id, output, $clog2(QUEUE_QUANTITY) bits; VC of the emitted word.
REQ-014 SHALL have port data_word, output, BUF_WIDTH+1 bits; emitted word.
REQ-015 SHALL have port full, output, QUEUE_QUANTITY bits; per-VC queue full flag (combinational from state).
REQ-016 SHALL have port wr_error, output, 1 bit; one-cycle pulse when a write is dropped.
REQ-017 SHALL have port paused, output, QUEUE_QUANTITY bits; per-VC pause state.
REQ-018 SHALL have port idle, output, 1 bit; high when all queues are empty and valid is 0.
REQ-019 SHALL have port sent_count, output, QUEUE_QUANTITY*8 bits; per-VC emitted-word counters, with VC0 in the LSBs.

Function
REQ-020 SHALL keep one FIFO of DEPTH words per VC, with independent read/write pointers and an occupancy count.
REQ-021 SHALL push wr_data into queue wr_vc on an edge with enb=1 and wr_en=1 when that queue is not full, or is full and is popped on the same edge.
REQ-022 SHALL otherwise drop the write and assert wr_error on the following cycle for exactly one cycle.
REQ-023 SHALL set paused[i] on an edge with pausa[i]=1, and clear it on an edge with continuar[i]=1 and pausa[i]=0 (pausa wins on a tie).
REQ-024 SHALL treat VC i as eligible on an edge when its queue is non-empty, paused[i]=0 and pausa[i]=0; pausa therefore blocks in the same cycle, while continuar takes effect one cycle later.
REQ-025 SHALL, on each edge with enb=1 and at least one eligible VC, pop exactly one word from the first eligible VC found searching upward from rr_ptr with wrap-around.
REQ-026 SHALL register the popped word in data_word, its VC in vc_id and set valid=1, giving one-cycle latency from selection to output.
REQ-027 SHALL set rr_ptr to (served VC + 1) mod QUEUE_QUANTITY after a pop.
REQ-028 SHALL, when no VC is eligible, set valid=0, hold vc_id/data_word and leave rr_ptr unchanged.
REQ-029 SHALL, with enb=0, freeze queues, pause state, rr_ptr and counters; valid=0, wr_error=0, and writes are ignored without error.
REQ-030 SHALL allow a push to and a pop from the same queue on one edge, leaving occupancy unchanged.
REQ-031 SHALL never emit a word written on the same edge; a written word is eligible from the next edge.

Reset
REQ-032 SHALL, on an edge with rst=1 and regardless of enb, empty all queues, clear paused, set rr_ptr=0, valid=0, vc_id=0, data_word=0, wr_error=0 and sent_count=0.
REQ-033 SHALL discard any word pending mid-operation at reset; idle=1 on the first cycle after reset.

Configuration
REQ-034 SHALL, with macro QOS_EMISOR_CONTADORES_EN defined, increment sent_count[i] by 1 on each emission on VC i, saturating at 255.
REQ-035 SHALL, without QOS_EMISOR_CONTADORES_EN, drive sent_count constant 0 and instantiate no counter registers.

Verification
REQ-036 SHALL cover: reset, then write VC0=8, VC1=5, VC2=2, VC3=3 -> valid words emitted in order vc 0,1,2,3 with data 8,5,2,3, one per cycle, then idle=1.
REQ-037 SHALL cover: five writes of 1..5 to VC2 with no pops (all VCs paused) -> full[2]=1 after the 4th write, 5th dropped with a one-cycle wr_error pulse.
REQ-038 SHALL cover: VC1 loaded with 10,3 and pausa[1] pulsed -> no VC1 emission while paused; continuar[1] pulse -> 10 emitted one cycle after paused[1] clears, then 3.
REQ-039 SHALL cover: pausa[3] and continuar[3] both high on one edge -> paused[3]=1.
REQ-040 SHALL cover: all four VCs holding two words each -> emission order 0,1,2,3,0,1,2,3; rst=1 asserted after the third word -> valid=0, all queues empty, next word written to VC3 emitted with vc_id=3.
REQ-041 SHALL cover: with QOS_EMISOR_CONTADORES_EN defined, 300 emissions on VC0 -> sent_count[7:0]=255; without the macro -> sent_count stays 0.
